// File: rtl/int_rf_mp_if.sv
// int_rf_mp_if: handshake/bus bundle for the multi-port integer register file.
// Ports: write lanes (valid/idx/data, ready), read lanes (idx, data),
// bulk clear (req, busy, done). master = client side, slave = register file.
interface int_rf_mp_if #(
    parameter int XLEN   = 64,
    parameter int IDX_W  = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
);
    logic [NUM_WR-1:0]            wr_valid_i;
    logic [NUM_WR-1:0][IDX_W-1:0] wr_idx_i;
    logic [NUM_WR-1:0][XLEN-1:0]  wr_data_i;
    logic                         wr_ready_o;
    logic [NUM_RD-1:0][IDX_W-1:0] rd_idx_i;
    logic [NUM_RD-1:0][XLEN-1:0]  rd_data_o;
    logic                         clr_req_i;
    logic                         clr_busy_o;
    logic                         clr_done_o;

    modport master (
        output wr_valid_i, wr_idx_i, wr_data_i,
        output rd_idx_i, clr_req_i,
        input  wr_ready_o, rd_data_o,
        input  clr_busy_o, clr_done_o
    );

    modport slave (
        input  wr_valid_i, wr_idx_i, wr_data_i,
        input  rd_idx_i, clr_req_i,
        output wr_ready_o, rd_data_o,
        output clr_busy_o, clr_done_o
    );
endinterface

// File: rtl/int_rf_mp.sv
// int_rf_mp: parametrised multi-port integer register file with async reads,
// sync prioritised writes and a sequential bulk-clear engine.
// Ports: clk_i, rst_n_i (async, active-low), bus (int_rf_mp_if.slave):
//   wr_valid_i/wr_idx_i/wr_data_i/wr_ready_o, rd_idx_i/rd_data_o,
//   clr_req_i/clr_busy_o/clr_done_o.
// Option: define LEN5_RF_BYPASS_EN to forward same-cycle write data to reads.
module int_rf_mp #(
    parameter int XLEN       = 64,
    parameter int REG_NUM    = 32,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1,
    parameter int ZERO_REG0  = 1,
    parameter int CLR_STRIDE = 4,
    localparam int IDX_W     = $clog2(REG_NUM)
) (
    input logic          clk_i,
    input logic          rst_n_i,
    int_rf_mp_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [IDX_W:0] LAST_PTR =
        (IDX_W+1)'(REG_NUM - CLR_STRIDE);
    localparam logic [IDX_W:0] STRIDE_W =
        (IDX_W+1)'(CLR_STRIDE);

    state_t           state_q;
    logic [IDX_W:0]   ptr_q;
    logic             busy_q;
    logic             done_q;

    logic [XLEN-1:0]  regs_q [REG_NUM];
    logic [XLEN-1:0]  regs_d [REG_NUM];

    logic             wr_ready;
    logic [NUM_RD-1:0][XLEN-1:0] rd_data;

    assign wr_ready       = !busy_q;
    assign bus.wr_ready_o = wr_ready;
    assign bus.clr_busy_o = busy_q;
    assign bus.clr_done_o = done_q;
    assign bus.rd_data_o  = rd_data;

    // Clear sequencer; busy/done are registered straight from the FSM.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.clr_req_i) begin
                        state_q <= CLEAR;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    ptr_q <= ptr_q + STRIDE_W;
                    if (ptr_q == LAST_PTR) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Next array contents. Ports are walked low to high so the
    // highest-numbered valid port wins an index collision.
    always_comb begin
        for (int i = 0; i < REG_NUM; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_ready) begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (bus.wr_valid_i[p] &&
                    (ZERO_REG0 == 0 || bus.wr_idx_i[p] != '0)) begin
                    regs_d[bus.wr_idx_i[p]] = bus.wr_data_i[p];
                end
            end
        end
        if (state_q == CLEAR) begin
            for (int i = 0; i < REG_NUM; i++) begin
                if ((IDX_W+1)'(i) >= ptr_q &&
                    (IDX_W+1)'(i) < ptr_q + STRIDE_W) begin
                    regs_d[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            rd_data[r] = regs_q[bus.rd_idx_i[r]];
`ifdef LEN5_RF_BYPASS_EN
            if (wr_ready) begin
                for (int p = 0; p < NUM_WR; p++) begin
                    if (bus.wr_valid_i[p] &&
                        bus.wr_idx_i[p] == bus.rd_idx_i[r]) begin
                        rd_data[r] = bus.wr_data_i[p];
                    end
                end
            end
`endif
            if (ZERO_REG0 != 0 && bus.rd_idx_i[r] == '0) begin
                rd_data[r] = '0;
            end
        end
    end

endmodule

// File: doc/int_rf_mp.md
Name: int_rf_mp

Overview:
- Parametrised multi-port integer register file; successor to the single-write/dual-read integer RF in the execution pipeline.
- Provides NUM_RD asynchronous read ports and NUM_WR synchronous write ports, so several commit lanes can retire per cycle and several issue lanes can read operands per cycle.
- Deterministic priority resolves colliding writes.
- A sequential bulk-clear engine zeroes the file after a flush or context switch.

Parameters:
- XLEN, 64, data width of each register.
- REG_NUM, 32, number of architectural registers; power of two, >= 2.
- NUM_RD, 2, number of read ports, >= 1.
- NUM_WR, 1, number of write ports, >= 1.
- ZERO_REG0, 1, 1: register 0 is hardwired to zero; 0: register 0 is an ordinary register.
- CLR_STRIDE, 4, registers zeroed per cycle by the clear engine; must divide REG_NUM.
- Derived (localparam): IDX_W = $clog2(REG_NUM).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- wr_valid_i  in  NUM_WR  per-port write enable.
- wr_idx_i  in  NUM_WR x IDX_W  per-port destination index.
- wr_data_i  in  NUM_WR x XLEN  per-port write data.
- wr_ready_o  out  1  write ports accept data; low while clearing.
- rd_idx_i  in  NUM_RD x IDX_W  per-port source index.
- rd_data_o  out  NUM_RD x XLEN  per-port read data, combinational.
- clr_req_i  in  1  bulk-clear request, sampled when idle.
- clr_busy_o  out  1  clear engine active.
- clr_done_o  out  1  one-cycle pulse when clear completes.

Behaviour:
Reset:
- All registers 0, FSM in IDLE, clear pointer 0.
- Outputs: clr_busy_o=0, clr_done_o=0, wr_ready_o=1.
- rd_data_o reflects the zeroed array.

Write:
- Port p writes on a clock edge when wr_valid_i[p] && wr_ready_o.
- Writes with wr_valid_i low are ignored.
- ZERO_REG0=1: writes to index 0 are dropped.
- Same-cycle collision on one index: the highest-numbered valid port wins; the other ports' data is discarded, with no error.

Read:
- Combinational.
- ZERO_REG0=1 and index 0: returns 0.
- Otherwise returns the stored value, or the bypassed value (see Optional Feature).
- Read latency 0; write visibility 1 cycle (no bypass).

Clear FSM (IDLE, CLEAR, DONE):
- IDLE: clr_req_i=1 -> CLEAR, pointer=0.
- CLEAR:
  - Each cycle zeroes registers [ptr, ptr+CLR_STRIDE-1], then ptr += CLR_STRIDE.
  - After the cycle that clears the last group (ptr = REG_NUM-CLR_STRIDE) -> DONE.
  - Takes exactly REG_NUM/CLR_STRIDE cycles in CLEAR.
- DONE: clr_done_o=1 for one cycle -> IDLE.
- clr_busy_o=1 in CLEAR and DONE. wr_ready_o = !clr_busy_o.
- clr_req_i while busy: ignored, not queued.
- clr_req_i in the same cycle as valid writes in IDLE: those writes commit (wr_ready_o still 1); clearing starts next cycle and later zeroes them.
- Reads during CLEAR return the current, partially cleared contents.
- Pointer width is IDX_W+1 to avoid wrap ambiguity.
- Reset asserted mid-clear: immediate full zero, IDLE, no clr_done_o pulse.

Optional Feature:
- Macro: LEN5_RF_BYPASS_EN.
- Defined: read port r returns wr_data_i of the winning (highest-numbered) port with wr_valid_i && wr_ready_o && wr_idx_i == rd_idx_i[r] in the same cycle. Zero-register rule still applies. No bypass while clearing, since wr_ready_o=0.
- Undefined: reads return stored contents only; new data is visible the cycle after the write edge.

Test Plan:
- Reset then read all indices on every port -> all 0; clr_busy_o=0, wr_ready_o=1.
- Write idx 5 = 0xDEAD_BEEF on port 0, next cycle read idx 5 on port 1 -> 0xDEAD_BEEF. Write idx 0 = 0x1 with ZERO_REG0=1 -> read idx 0 = 0.
- NUM_WR=2: port0 idx 7=0xAAAA, port1 idx 7=0x5555 in the same cycle -> idx 7 = 0x5555.
- Fill regs 1..31 with value = index, pulse clr_req_i -> clr_busy_o high 8 CLEAR cycles + 1 DONE cycle (REG_NUM=32, CLR_STRIDE=4); clr_done_o pulses once; wr_valid_i during busy is ignored; afterwards all regs 0.
- Assert rst_n_i low after 3 CLEAR cycles -> all regs 0 immediately, FSM IDLE, no clr_done_o pulse.
- LEN5_RF_BYPASS_EN defined: write idx 9=0x1234 while reading idx 9 in the same cycle -> rd_data_o=0x1234. Undefined: same stimulus returns the old value, then 0x1234 the next cycle.
